ntt_bfu_sched: RTL and testbench
================================

Name: ntt_bfu_sched

Overview:
- Sequencer for the 5-stage pipelined butterfly unit (BFU) and its coefficient RAM. It runs one complete N-point forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) per start pulse.
- Issues one butterfly per cycle: coefficient read address pair, twiddle ROM address and BFU mode.
- Replays the write-back address pair after the fixed datapath latency.
- Drains the pipeline at every stage boundary, so read-after-write hazards cannot occur.

Parameters:
- N, 256, transform length; power of two, minimum 4.
- LOGN, 8, log2(N); number of stages.
- ADDR_W, 8, coefficient/twiddle address width, equal to LOGN.
- PIPE_LAT, 6, cycles from oRD_EN to the matching oWR_EN (1 RAM read + 5 BFU).

Ports:
- iSYS_CLK  in  1  system clock, rising edge.
- iSYS_RST  in  1  asynchronous, active-low reset.
- iFSM_START  in  1  start pulse; sampled in IDLE only.
- iMODE  in  1  0 = forward CT, 1 = inverse GS; latched at start.
- oBUSY  out  1  high from the cycle after start until DONE is exited.
- oDONE  out  1  one-cycle completion pulse.
- oBFU_SEL  out  1  latched mode, driven to the BFU sel input.
- oRD_EN  out  1  butterfly issue strobe.
- oRD_ADDR_A  out  ADDR_W  read address, top butterfly input.
- oRD_ADDR_B  out  ADDR_W  read address, bottom butterfly input.
- oTW_ADDR  out  ADDR_W  twiddle ROM index.
- oWR_EN  out  1  write-back strobe.
- oWR_ADDR_A  out  ADDR_W  write address, BFU oA.
- oWR_ADDR_B  out  ADDR_W  write address, BFU oB.
- oSTAGE  out  $clog2(LOGN)+1  current stage index.

Behaviour:
- Reset (iSYS_RST=0, asynchronous):
  - All outputs are 0 and the FSM returns to IDLE.
  - The delay line is cleared, so no stray writes occur after reset.
  - Reset asserted mid-operation aborts the transform with no oDONE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - iFSM_START=1 latches iMODE into oBFU_SEL and initialises the counters.
  - Next state is ISSUE; the first oRD_EN occurs in the cycle after start.
- ISSUE: exactly N/2 cycles with oRD_EN=1 and one butterfly per cycle. After the last issue the FSM enters DRAIN.
- DRAIN:
  - Exactly PIPE_LAT cycles with oRD_EN=0.
  - Exit goes to ISSUE for the next stage, or to DONE after stage LOGN-1.
  - The last write of a stage happens in the final DRAIN cycle; the next stage's first read follows one cycle later.
- DONE: one cycle with oDONE=1 and oBUSY=1, then IDLE.
- Total cycles from start to oDONE inclusive: LOGN*(N/2+PIPE_LAT)+1. For N=256 and PIPE_LAT=6 this is 1073.
- Forward address generation (iMODE=0):
  - len = N/2 down to 1, halving each stage; k starts at 0.
  - Each group: k = k+1, and oTW_ADDR = k.
  - Each j in [start, start+len): oRD_ADDR_A = j, oRD_ADDR_B = j+len.
  - Next group: start = start + 2*len.
- Inverse address generation (iMODE=1):
  - len = 1 up to N/2, doubling each stage; k starts at N.
  - Each group: k = k-1, and oTW_ADDR = k.
  - Pairing is the same as forward.
  - Twiddle negation and scaling belong to the ROM/BFU, not to this block.
- Counters:
  - Counter width is ADDR_W bits.
  - The group/j counters wrap cleanly at stage end.
  - k never leaves [1, N-1] during issue.
- Write-back:
  - oWR_EN, oWR_ADDR_A and oWR_ADDR_B equal oRD_EN, oRD_ADDR_A and oRD_ADDR_B delayed by exactly PIPE_LAT cycles.
  - This is implemented as a shift register, not recomputed.
- Start handling:
  - iFSM_START while oBUSY=1 is ignored, and iMODE changes during the run are ignored.
  - iFSM_START in the same cycle as the DONE state is ignored.
  - iFSM_START held high continuously restarts a new transform in the cycle after returning to IDLE.
- oSTAGE holds the index of the stage being issued or drained; it is 0 in IDLE.

Optional Feature:
- Macro: NTT_SCHED_PERF_EN.
- When defined:
  - Adds output oCYC_CNT [15:0], a cycle counter that clears on start, increments while oBUSY=1, and freezes at oDONE.
  - Adds output oISSUE_CNT [15:0], a count of issued butterflies; it must equal LOGN*N/2 at oDONE.
- When undefined, neither port nor its logic exists.

Decomposition:
- Shared package ntt_pkg holds:
  - the N, LOGN and ADDR_W defaults;
  - the mode constants MODE_CT=0 and MODE_GS=1;
  - the FSM state encoding.
- One sub-module, ntt_wr_delay: a PIPE_LAT-deep shift register carrying {valid, addrA, addrB}, with asynchronous active-low clear.

Test Plan:
- Forward, N=256:
  - start with iMODE=0 -> first issue (0,128) with tw 1, then (1,129) with tw 1;
  - stage 1 first issue (0,64) with tw 2, exactly 6 idle cycles after the last stage-0 issue;
  - last issue (254,255) with tw 255;
  - oDONE at cycle 1073.
- Inverse, N=256:
  - iMODE=1 -> first issue (0,1) with tw 255, then (2,3) with tw 254;
  - last issue (127,255) with tw 1;
  - oBFU_SEL=1 throughout.
- Write-back:
  - every oWR_EN pulse matches the oRD_EN pulse of PIPE_LAT cycles earlier, with identical addresses;
  - 1024 writes total per run.
- Start handling:
  - pulse iFSM_START at cycle 300 with iMODE toggled -> no effect; sequence and mode unchanged.
  - hold iFSM_START high continuously -> back-to-back transforms.
- Reset mid-operation: assert iSYS_RST=0 at cycle 500 -> all outputs 0 immediately; no further oWR_EN and no oDONE; a fresh start afterwards runs normally.
- Small-N instance: N=8, PIPE_LAT=6, forward -> pairs (0,4)…(3,7), (0,2),(1,3),(4,6),(5,7), (0,1)…(6,7); tw 1,2,3,4,5,6,7; oDONE at cycle 31.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared defaults, BFU mode constants and sequencer state encoding for the NTT datapath.
package ntt_pkg;
  localparam int NTT_N        = 256;
  localparam int NTT_LOGN     = 8;
  localparam int NTT_ADDR_W   = 8;
  localparam int NTT_PIPE_LAT = 6;

  localparam logic MODE_CT = 1'b0;
  localparam logic MODE_GS = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fsmState_t;
endpackage

// File: rtl/ntt_wr_delay.sv
// Write-back replay line: carries {valid, addrA, addrB} through PIPE_LAT registers.
module ntt_wr_delay #(
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 6
) (
  input  logic              iSYS_CLK,
  input  logic              iSYS_RST,
  input  logic              iVLD,
  input  logic [ADDR_W-1:0] iADDR_A,
  input  logic [ADDR_W-1:0] iADDR_B,
  output logic              oVLD,
  output logic [ADDR_W-1:0] oADDR_A,
  output logic [ADDR_W-1:0] oADDR_B
);
  logic              vldPipe   [PIPE_LAT];
  logic [ADDR_W-1:0] addrAPipe [PIPE_LAT];
  logic [ADDR_W-1:0] addrBPipe [PIPE_LAT];

  // Addresses are cleared with the strobe so nothing stale reaches the RAM after reset.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        vldPipe[i]   <= 1'b0;
        addrAPipe[i] <= '0;
        addrBPipe[i] <= '0;
      end
    end else begin
      vldPipe[0]   <= iVLD;
      addrAPipe[0] <= iADDR_A;
      addrBPipe[0] <= iADDR_B;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vldPipe[i]   <= vldPipe[i-1];
        addrAPipe[i] <= addrAPipe[i-1];
        addrBPipe[i] <= addrBPipe[i-1];
      end
    end
  end

  assign oVLD    = vldPipe[PIPE_LAT-1];
  assign oADDR_A = addrAPipe[PIPE_LAT-1];
  assign oADDR_B = addrBPipe[PIPE_LAT-1];
endmodule

// File: rtl/ntt_bfu_sched.sv
// NTT butterfly sequencer: N/2 issues per stage, PIPE_LAT-cycle drain between stages.
// Define NTT_SCHED_PERF_EN to add the oCYC_CNT / oISSUE_CNT performance counters.
module ntt_bfu_sched
  import ntt_pkg::*;
#(
  parameter int N        = NTT_N,
  parameter int LOGN     = NTT_LOGN,
  parameter int ADDR_W   = NTT_ADDR_W,
  parameter int PIPE_LAT = NTT_PIPE_LAT
) (
  input  logic                  iSYS_CLK,
  input  logic                  iSYS_RST,
  input  logic                  iFSM_START,
  input  logic                  iMODE,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic                  oBFU_SEL,
  output logic                  oRD_EN,
  output logic [ADDR_W-1:0]     oRD_ADDR_A,
  output logic [ADDR_W-1:0]     oRD_ADDR_B,
  output logic [ADDR_W-1:0]     oTW_ADDR,
  output logic                  oWR_EN,
  output logic [ADDR_W-1:0]     oWR_ADDR_A,
  output logic [ADDR_W-1:0]     oWR_ADDR_B,
  output logic [$clog2(LOGN):0] oSTAGE
`ifdef NTT_SCHED_PERF_EN
  ,
  output logic [15:0]           oCYC_CNT,
  output logic [15:0]           oISSUE_CNT
`endif
);
  localparam int STAGE_W = $clog2(LOGN) + 1;
  localparam int DRAIN_W = $clog2(PIPE_LAT + 1);
  localparam logic [ADDR_W-1:0]  ONE        = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  LEN_CT     = ADDR_W'(N / 2);
  localparam logic [ADDR_W-1:0]  K_GS       = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0]  LAST_ISSUE = ADDR_W'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOGN - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

  fsmState_t          state;
  logic [ADDR_W-1:0]  base, off, len, k, issueCnt;
  logic [DRAIN_W-1:0] drainCnt;
  logic [ADDR_W-1:0]  baseNext, offNext, kStep, kNext, lenNext, lenInit, kInit;
  logic               grpEnd, isGs;

  // base/off/len/k describe the butterfly currently on the read outputs.
  always_comb begin
    isGs     = (oBFU_SEL == MODE_GS);
    grpEnd   = (off == len - ONE);
    kNext    = isGs ? k - ONE : k + ONE;
    lenNext  = isGs ? len << 1 : len >> 1;
    baseNext = base;
    offNext  = off + ONE;
    kStep    = k;
    if (grpEnd) begin
      baseNext = base + (len << 1);
      offNext  = '0;
      kStep    = kNext;
    end
    lenInit = (iMODE == MODE_GS) ? ONE : LEN_CT;
    kInit   = (iMODE == MODE_GS) ? K_GS : ONE;
  end

  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      state      <= S_IDLE;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oBFU_SEL   <= MODE_CT;
      oRD_EN     <= 1'b0;
      oRD_ADDR_A <= '0;
      oRD_ADDR_B <= '0;
      oTW_ADDR   <= '0;
      oSTAGE     <= '0;
      base       <= '0;
      off        <= '0;
      len        <= '0;
      k          <= '0;
      issueCnt   <= '0;
      drainCnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (iFSM_START) begin
            oBFU_SEL   <= iMODE;
            oBUSY      <= 1'b1;
            oSTAGE     <= '0;
            base       <= '0;
            off        <= '0;
            len        <= lenInit;
            k          <= kInit;
            issueCnt   <= '0;
            oRD_EN     <= 1'b1;
            oRD_ADDR_A <= '0;
            oRD_ADDR_B <= lenInit;
            oTW_ADDR   <= kInit;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issueCnt == LAST_ISSUE) begin
            // The last issue of a stage always closes a group, so k steps here too.
            oRD_EN     <= 1'b0;
            oRD_ADDR_A <= '0;
            oRD_ADDR_B <= '0;
            oTW_ADDR   <= '0;
            base       <= '0;
            off        <= '0;
            len        <= lenNext;
            k          <= kNext;
            drainCnt   <= '0;
            state      <= S_DRAIN;
          end else begin
            base       <= baseNext;
            off        <= offNext;
            k          <= kStep;
            issueCnt   <= issueCnt + ONE;
            oRD_ADDR_A <= baseNext + offNext;
            oRD_ADDR_B <= baseNext + offNext + len;
            oTW_ADDR   <= kStep;
          end
        end
        S_DRAIN: begin
          if (drainCnt == LAST_DRAIN) begin
            if (oSTAGE == LAST_STAGE) begin
              oDONE <= 1'b1;
              state <= S_DONE;
            end else begin
              oSTAGE     <= oSTAGE + 1'b1;
              issueCnt   <= '0;
              oRD_EN     <= 1'b1;
              oRD_ADDR_A <= '0;
              oRD_ADDR_B <= len;
              oTW_ADDR   <= k;
              state      <= S_ISSUE;
            end
          end else begin
            drainCnt <= drainCnt + 1'b1;
          end
        end
        S_DONE: begin
          oDONE  <= 1'b0;
          oBUSY  <= 1'b0;
          oSTAGE <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ntt_wr_delay #(
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PIPE_LAT)
  ) u_wr_delay (
    .iSYS_CLK (iSYS_CLK),
    .iSYS_RST (iSYS_RST),
    .iVLD     (oRD_EN),
    .iADDR_A  (oRD_ADDR_A),
    .iADDR_B  (oRD_ADDR_B),
    .oVLD     (oWR_EN),
    .oADDR_A  (oWR_ADDR_A),
    .oADDR_B  (oWR_ADDR_B)
  );

`ifdef NTT_SCHED_PERF_EN
  // Cycle count stops advancing once oDONE is up and holds until the next start.
  always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
    if (!iSYS_RST) begin
      oCYC_CNT   <= '0;
      oISSUE_CNT <= '0;
    end else if (state == S_IDLE && iFSM_START) begin
      oCYC_CNT   <= '0;
      oISSUE_CNT <= '0;
    end else begin
      if (oBUSY && !oDONE) oCYC_CNT <= oCYC_CNT + 16'd1;
      if (oRD_EN) oISSUE_CNT <= oISSUE_CNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ntt_bfu_sched.sv
// Directed bench for ntt_bfu_sched: N=256 forward/inverse runs, start handling, reset abort, N=8 instance.
module tb_ntt_bfu_sched;
  localparam int BN          = 256;
  localparam int HALF        = BN / 2;
  localparam int LAT         = 6;
  localparam int ISSUE_TOTAL = 1024;
  localparam int DONE_CYC    = 1073;

  typedef struct {
    logic mode;
    int   idx;
    int   a;
    int   b;
    int   tw;
  } vec_t;

  typedef struct {
    int a;
    int b;
    int tw;
  } svec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       startS = 1'b0;
  logic       modeS = 1'b0;

  logic       oBUSY, oDONE, oBFU_SEL, oRD_EN, oWR_EN;
  logic [7:0] oRD_ADDR_A, oRD_ADDR_B, oTW_ADDR, oWR_ADDR_A, oWR_ADDR_B;
  logic [3:0] oSTAGE;

  logic       sBusy, sDone, sSel, sRdEn, sWrEn;
  logic [2:0] sRdA, sRdB, sTw, sWrA, sWrB;
  logic [2:0] sStage;

`ifdef NTT_SCHED_PERF_EN
  logic [15:0] cycCnt, issCnt, cycCntS, issCntS;
`endif

  int nChecks = 0;
  int nFails  = 0;

  int expA [ISSUE_TOTAL];
  int expB [ISSUE_TOTAL];
  int expTw[ISSUE_TOTAL];
  int capA [ISSUE_TOTAL];
  int capB [ISSUE_TOTAL];
  int capTw[ISSUE_TOTAL];
  int capCyc[ISSUE_TOTAL];

  vec_t  vecs [14];
  svec_t sVecs[12];

  always #5 clk = ~clk;

  ntt_bfu_sched dut (
    .iSYS_CLK   (clk),
    .iSYS_RST   (rst),
    .iFSM_START (start),
    .iMODE      (mode),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oBFU_SEL   (oBFU_SEL),
    .oRD_EN     (oRD_EN),
    .oRD_ADDR_A (oRD_ADDR_A),
    .oRD_ADDR_B (oRD_ADDR_B),
    .oTW_ADDR   (oTW_ADDR),
    .oWR_EN     (oWR_EN),
    .oWR_ADDR_A (oWR_ADDR_A),
    .oWR_ADDR_B (oWR_ADDR_B),
    .oSTAGE     (oSTAGE)
`ifdef NTT_SCHED_PERF_EN
    ,
    .oCYC_CNT   (cycCnt),
    .oISSUE_CNT (issCnt)
`endif
  );

  ntt_bfu_sched #(.N(8), .LOGN(3), .ADDR_W(3), .PIPE_LAT(6)) dutS (
    .iSYS_CLK   (clk),
    .iSYS_RST   (rst),
    .iFSM_START (startS),
    .iMODE      (modeS),
    .oBUSY      (sBusy),
    .oDONE      (sDone),
    .oBFU_SEL   (sSel),
    .oRD_EN     (sRdEn),
    .oRD_ADDR_A (sRdA),
    .oRD_ADDR_B (sRdB),
    .oTW_ADDR   (sTw),
    .oWR_EN     (sWrEn),
    .oWR_ADDR_A (sWrA),
    .oWR_ADDR_B (sWrB),
    .oSTAGE     (sStage)
`ifdef NTT_SCHED_PERF_EN
    ,
    .oCYC_CNT   (cycCntS),
    .oISSUE_CNT (issCntS)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    nChecks++;
    if (act != req) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference issue order straight from the CT/GS loop nest.
  task automatic buildModel(input logic m);
    int len, kk, idx;
    len = m ? 1 : BN / 2;
    kk  = m ? BN : 0;
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      for (int st = 0; st < BN; st += 2 * len) begin
        kk = m ? kk - 1 : kk + 1;
        for (int j = st; j < st + len; j++) begin
          expA[idx]  = j;
          expB[idx]  = j + len;
          expTw[idx] = kk;
          idx++;
        end
      end
      len = m ? len * 2 : len / 2;
    end
  endtask

  task automatic runXform(input logic m, input bit pulse300, input bit hold, input string tag);
    int cyc, nIss, nWr, seqErr, cycErr, wrErr, selErr, busyErr, doneCyc;
    bit doneSeen;
    buildModel(m);
    cyc = 0; nIss = 0; nWr = 0; seqErr = 0; cycErr = 0; wrErr = 0;
    selErr = 0; busyErr = 0; doneCyc = 0; doneSeen = 1'b0;
    start = 1'b1;
    mode  = m;
    while (!doneSeen && cyc < 1200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && !hold) start = 1'b0;
      if (pulse300 && cyc == 300) begin
        start = 1'b1;
        mode  = ~m;
      end
      if (pulse300 && cyc == 301) start = 1'b0;
      if (oBUSY !== 1'b1) busyErr++;
      if (oBFU_SEL !== m) selErr++;
      if (oRD_EN === 1'b1) begin
        if (nIss < ISSUE_TOTAL) begin
          capA[nIss]   = int'(oRD_ADDR_A);
          capB[nIss]   = int'(oRD_ADDR_B);
          capTw[nIss]  = int'(oTW_ADDR);
          capCyc[nIss] = cyc;
          if (capA[nIss] != expA[nIss] || capB[nIss] != expB[nIss] ||
              capTw[nIss] != expTw[nIss] || int'(oSTAGE) != nIss / HALF) seqErr++;
          if (cyc != 1 + (nIss / HALF) * (HALF + LAT) + nIss % HALF) cycErr++;
        end
        nIss++;
      end
      if (oWR_EN === 1'b1) begin
        if (nWr < nIss && nWr < ISSUE_TOTAL) begin
          if (int'(oWR_ADDR_A) != capA[nWr] || int'(oWR_ADDR_B) != capB[nWr] ||
              cyc != capCyc[nWr] + LAT) wrErr++;
        end else begin
          wrErr++;
        end
        nWr++;
      end
      if (oDONE === 1'b1) begin
        doneSeen = 1'b1;
        doneCyc  = cyc;
      end
    end
    check({tag, " done cycle"}, doneCyc, DONE_CYC);
    check({tag, " issue count"}, nIss, ISSUE_TOTAL);
    check({tag, " write count"}, nWr, ISSUE_TOTAL);
    check({tag, " issue sequence errors"}, seqErr, 0);
    check({tag, " issue timing errors"}, cycErr, 0);
    check({tag, " write-back errors"}, wrErr, 0);
    check({tag, " bfu sel errors"}, selErr, 0);
    check({tag, " busy errors"}, busyErr, 0);
`ifdef NTT_SCHED_PERF_EN
    check({tag, " perf issue count"}, int'(issCnt), ISSUE_TOTAL);
    check({tag, " perf cycle count"}, int'(cycCnt), DONE_CYC - 1);
`endif
    foreach (vecs[i]) begin
      if (vecs[i].mode == m) begin
        check($sformatf("%s issue %0d addrA", tag, vecs[i].idx), capA[vecs[i].idx], vecs[i].a);
        check($sformatf("%s issue %0d addrB", tag, vecs[i].idx), capB[vecs[i].idx], vecs[i].b);
        check($sformatf("%s issue %0d tw", tag, vecs[i].idx), capTw[vecs[i].idx], vecs[i].tw);
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      check({tag, " busy after done"}, int'(oBUSY), 0);
      check({tag, " done pulse width"}, int'(oDONE), 0);
      check({tag, " stage in idle"}, int'(oSTAGE), 0);
    end
  endtask

  initial begin
    int cyc, n, sw, dc, stray;
    bit doneS;

    vecs[0]  = '{1'b0, 0,    0,   128, 1};
    vecs[1]  = '{1'b0, 1,    1,   129, 1};
    vecs[2]  = '{1'b0, 127,  127, 255, 1};
    vecs[3]  = '{1'b0, 128,  0,   64,  2};
    vecs[4]  = '{1'b0, 192,  128, 192, 3};
    vecs[5]  = '{1'b0, 256,  0,   32,  4};
    vecs[6]  = '{1'b0, 1023, 254, 255, 255};
    vecs[7]  = '{1'b1, 0,    0,   1,   255};
    vecs[8]  = '{1'b1, 1,    2,   3,   254};
    vecs[9]  = '{1'b1, 128,  0,   2,   127};
    vecs[10] = '{1'b1, 129,  1,   3,   127};
    vecs[11] = '{1'b1, 130,  4,   6,   126};
    vecs[12] = '{1'b1, 1022, 126, 254, 1};
    vecs[13] = '{1'b1, 1023, 127, 255, 1};

    sVecs[0]  = '{0, 4, 1};
    sVecs[1]  = '{1, 5, 1};
    sVecs[2]  = '{2, 6, 1};
    sVecs[3]  = '{3, 7, 1};
    sVecs[4]  = '{0, 2, 2};
    sVecs[5]  = '{1, 3, 2};
    sVecs[6]  = '{4, 6, 3};
    sVecs[7]  = '{5, 7, 3};
    sVecs[8]  = '{0, 1, 4};
    sVecs[9]  = '{2, 3, 5};
    sVecs[10] = '{4, 5, 6};
    sVecs[11] = '{6, 7, 7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(oBUSY), 0);
    check("reset done", int'(oDONE), 0);
    check("reset rd_en", int'(oRD_EN), 0);
    check("reset wr_en", int'(oWR_EN), 0);
    check("reset stage", int'(oSTAGE), 0);
    check("reset sel", int'(oBFU_SEL), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    runXform(1'b0, 1'b0, 1'b0, "fwd");
    check("fwd stage0->1 gap", capCyc[128] - capCyc[127], LAT + 1);

    runXform(1'b1, 1'b1, 1'b0, "inv");

    // Start held high: DONE ignores it, IDLE takes it, next run issues right after.
    runXform(1'b1, 1'b0, 1'b1, "hold");
    @(posedge clk); #1;
    check("hold idle busy", int'(oBUSY), 0);
    check("hold idle rd_en", int'(oRD_EN), 0);
    @(posedge clk); #1;
    check("hold restart busy", int'(oBUSY), 1);
    check("hold restart rd_en", int'(oRD_EN), 1);
    check("hold restart addrB", int'(oRD_ADDR_B), 1);
    check("hold restart tw", int'(oTW_ADDR), 255);
    start = 1'b0;

    // Abort at cycle 500 of the restarted run.
    repeat (499) @(posedge clk);
    #1;
    check("pre-abort rd_en", int'(oRD_EN), 1);
    rst = 1'b0;
    #1;
    check("abort busy", int'(oBUSY), 0);
    check("abort rd_en", int'(oRD_EN), 0);
    check("abort wr_en", int'(oWR_EN), 0);
    check("abort rd addrA", int'(oRD_ADDR_A), 0);
    check("abort rd addrB", int'(oRD_ADDR_B), 0);
    check("abort tw", int'(oTW_ADDR), 0);
    check("abort wr addrB", int'(oWR_ADDR_B), 0);
    check("abort stage", int'(oSTAGE), 0);
    check("abort sel", int'(oBFU_SEL), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (oWR_EN !== 1'b0 || oDONE !== 1'b0 || oBUSY !== 1'b0) stray++;
    end
    check("post-abort stray activity", stray, 0);

    runXform(1'b0, 1'b0, 1'b0, "fresh");

    // N=8 forward instance
    cyc = 0; n = 0; sw = 0; dc = 0; doneS = 1'b0;
    startS = 1'b1;
    modeS  = 1'b0;
    while (!doneS && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) startS = 1'b0;
      if (sRdEn === 1'b1) begin
        if (n < 12) begin
          capA[n]  = int'(sRdA);
          capB[n]  = int'(sRdB);
          capTw[n] = int'(sTw);
        end
        n++;
      end
      if (sWrEn === 1'b1) sw++;
      if (sDone === 1'b1) begin
        doneS = 1'b1;
        dc    = cyc;
      end
    end
    check("n8 done cycle", dc, 31);
    check("n8 issue count", n, 12);
    check("n8 write count", sw, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("n8 issue %0d addrA", i), capA[i], sVecs[i].a);
      check($sformatf("n8 issue %0d addrB", i), capB[i], sVecs[i].b);
      check($sformatf("n8 issue %0d tw", i), capTw[i], sVecs[i].tw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule
